// File: rtl/tile_feedback_drawer_pkg.sv
// Shared definitions for the tile feedback drawer.
//   state_e       : drawer FSM state encoding
//   COLOUR_BG     : fill colour for a correct hit
//   COLOUR_MISS   : fill colour for a miss
//   SCREEN_*      : screen geometry shared by the drawing blocks
//   COORD_W       : width of the unclipped y sum, wide enough for
//                   row*TILE_H + offset + dy without wrapping
package piano_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRAW   = 2'd1,
    ST_FINISH = 2'd2,
    ST_REJECT = 2'd3
  } state_e;

  localparam logic [2:0] COLOUR_BG   = 3'b111;
  localparam logic [2:0] COLOUR_MISS = 3'b100;

  localparam int SCREEN_W     = 320;
  localparam int SCREEN_H_DEF = 240;
  localparam int COORD_W      = 10;

  function automatic logic [2:0] mode_colour(input logic miss);
    return miss ? COLOUR_MISS : COLOUR_BG;
  endfunction

endpackage

// File: rtl/tile_feedback_drawer_if.sv
// Request / pixel-stream bundle between a requester and the drawer.
//   go, mode, lane, row, offset : request (requester -> drawer)
//   x, y, colour, plot          : pixel write stream (drawer -> requester)
//   busy, done, err             : status (drawer -> requester)
// LW must equal the drawer's lane width, $clog2(NUM_LANES+1).
interface tile_feedback_drawer_if #(
  parameter int LW       = 3,
  parameter int ROW_W    = 3,
  parameter int OFFSET_W = 6
) ();

  logic                go;
  logic                mode;
  logic [LW-1:0]       lane;
  logic [ROW_W-1:0]    row;
  logic [OFFSET_W-1:0] offset;

  logic [8:0]          x;
  logic [7:0]          y;
  logic [2:0]          colour;
  logic                plot;
  logic                busy;
  logic                done;
  logic                err;

  modport master (
    output go, mode, lane, row, offset,
    input  x, y, colour, plot, busy, done, err
  );

  modport slave (
    input  go, mode, lane, row, offset,
    output x, y, colour, plot, busy, done, err
  );

endinterface

// File: rtl/tile_feedback_drawer_pixel_scan_counter.sv
// Row-major pixel scan counter for a W x H tile.
//   clk_i   : rising-edge clock
//   rst_i   : synchronous active-high reset
//   clear_i : restart the scan at (0,0); wins over en_i
//   en_i    : advance one pixel
//   dx_o    : column inside the tile, 0..W-1 (inner index)
//   dy_o    : row inside the tile, 0..H-1 (outer index)
//   last_o  : current position is the final pixel (W-1, H-1)
module pixel_scan_counter #(
  parameter int W = 40,
  parameter int H = 30,
  localparam int DXW = (W > 1) ? $clog2(W) : 1,
  localparam int DYW = (H > 1) ? $clog2(H) : 1
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           clear_i,
  input  logic           en_i,
  output logic [DXW-1:0] dx_o,
  output logic [DYW-1:0] dy_o,
  output logic           last_o
);

  localparam logic [DXW-1:0] DX_LAST = DXW'(W - 1);
  localparam logic [DYW-1:0] DY_LAST = DYW'(H - 1);

  logic [DXW-1:0] dx_q;
  logic [DYW-1:0] dy_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      dx_q <= '0;
      dy_q <= '0;
    end else if (en_i) begin
      if (dx_q == DX_LAST) begin
        dx_q <= '0;
        dy_q <= (dy_q == DY_LAST) ? '0 : dy_q + 1'b1;
      end else begin
        dx_q <= dx_q + 1'b1;
      end
    end
  end

  assign dx_o   = dx_q;
  assign dy_o   = dy_q;
  assign last_o = (dx_q == DX_LAST) && (dy_q == DY_LAST);

endmodule

// File: rtl/tile_feedback_drawer.sv
// Draws one solid-colour feedback tile as a stream of pixel writes.
//   clock_i : rising-edge system clock
//   reset_i : synchronous active-high reset
//   bus     : slave side of tile_feedback_drawer_if
//             request go/mode/lane/row/offset in,
//             pixel x/y/colour/plot and busy/done/err out
// A request is accepted in IDLE and latched; the tile is then swept
// row-major, one pixel per cycle, with rows below the screen clipped.
// All outputs are registered, so pixel k of a tile accepted at edge N
// appears in cycle N+1+k.
module tile_feedback_drawer
  import piano_pkg::*;
#(
  parameter int NUM_LANES = 4,
  parameter int TILE_W    = 40,
  parameter int TILE_H    = 30,
  parameter int X0        = 80,
  parameter int SCREEN_H  = SCREEN_H_DEF,
  parameter int ROW_W     = 3,
  parameter int OFFSET_W  = 6
) (
  input  logic                  clock_i,
  input  logic                  reset_i,
  tile_feedback_drawer_if.slave bus
);

  // One extra code point beyond the lane count so an out-of-range lane
  // index can actually be presented and rejected.
  localparam int LW  = $clog2(NUM_LANES + 1);
  localparam int DXW = (TILE_W > 1) ? $clog2(TILE_W) : 1;
  localparam int DYW = (TILE_H > 1) ? $clog2(TILE_H) : 1;

  localparam logic [LW-1:0]      LANE_LIM = LW'(NUM_LANES);
  localparam logic [DXW-1:0]     DX_LAST  = DXW'(TILE_W - 1);
  localparam logic [COORD_W-1:0] Y_LIMIT  = COORD_W'(SCREEN_H);

  state_e             state_q;
  logic               mode_q;
  logic [8:0]         xb_q;
  logic [COORD_W-1:0] yb_q;
  logic [8:0]         x_q;
  logic [7:0]         y_q;
  logic [2:0]         colour_q;
  logic               plot_q;
  logic               busy_q;
  logic               done_q;
  logic               err_q;

  logic [DXW-1:0]     dx;
  logic [DYW-1:0]     dy;
  logic               last;

  logic               lane_ok;
  logic               accept;
  logic [8:0]         acc_x;
  logic [COORD_W-1:0] acc_y;
  logic [DXW-1:0]     dx_d;
  logic [DYW-1:0]     dy_d;
  logic [8:0]         x_d;
  logic [COORD_W-1:0] y_d;

  always_comb begin
    lane_ok = (bus.lane < LANE_LIM);
    accept  = (state_q == ST_IDLE) && bus.go && lane_ok;
    acc_x   = 9'(X0) + 9'(bus.lane) * 9'(TILE_W);
    acc_y   = COORD_W'(bus.row) * COORD_W'(TILE_H) + COORD_W'(bus.offset);

    // Outputs are registered one cycle ahead of the scan counter, so the
    // value loaded each DRAW edge is for the pixel after (dx, dy).
    dx_d = dx;
    dy_d = dy;
    if (dx == DX_LAST) begin
      dx_d = '0;
      dy_d = dy + 1'b1;
    end else begin
      dx_d = dx + 1'b1;
    end
    x_d = xb_q + 9'(dx_d);
    y_d = yb_q + COORD_W'(dy_d);
  end

  pixel_scan_counter #(
    .W (TILE_W),
    .H (TILE_H)
  ) u_scan (
    .clk_i   (clock_i),
    .rst_i   (reset_i),
    .clear_i (accept),
    .en_i    (state_q == ST_DRAW),
    .dx_o    (dx),
    .dy_o    (dy),
    .last_o  (last)
  );

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q  <= ST_IDLE;
      mode_q   <= 1'b0;
      xb_q     <= '0;
      yb_q     <= '0;
      x_q      <= '0;
      y_q      <= '0;
      colour_q <= '0;
      plot_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          err_q  <= 1'b0;
          if (bus.go && lane_ok) begin
            state_q  <= ST_DRAW;
            mode_q   <= bus.mode;
            xb_q     <= acc_x;
            yb_q     <= acc_y;
            x_q      <= acc_x;
            y_q      <= acc_y[7:0];
            colour_q <= mode_colour(bus.mode);
            plot_q   <= (acc_y < Y_LIMIT);
            busy_q   <= 1'b1;
          end else if (bus.go) begin
            state_q <= ST_REJECT;
            err_q   <= 1'b1;
            done_q  <= 1'b1;
            busy_q  <= 1'b1;
          end
        end

        ST_DRAW: begin
          if (last) begin
            state_q  <= ST_FINISH;
            x_q      <= '0;
            y_q      <= '0;
            colour_q <= '0;
            plot_q   <= 1'b0;
            done_q   <= 1'b1;
          end else begin
            x_q      <= x_d;
            y_q      <= y_d[7:0];
            colour_q <= mode_colour(mode_q);
            plot_q   <= (y_d < Y_LIMIT);
          end
        end

        ST_FINISH: begin
          state_q <= ST_IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end

        ST_REJECT: begin
          state_q <= ST_IDLE;
          err_q   <= 1'b0;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end

        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.x      = x_q;
  assign bus.y      = y_q;
  assign bus.colour = colour_q;
  assign bus.plot   = plot_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.err    = err_q;

endmodule

// File: tb/tb_tile_feedback_drawer.sv
// Bench for tile_feedback_drawer: a default-parameter instance (A) and an
// 8-lane, 20-pixel-wide instance (B), exercised one at a time through a
// shared driver selected by sel. Expected pixels come from the tile
// geometry: pixel k of a tile sits at column k%W, row k/W.
module tb_tile_feedback_drawer;
  import piano_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       sel;
  logic       go;
  logic       mode;
  int         lane;
  logic [2:0] row;
  logic [5:0] offset;

  int vecs   = 0;
  int misses = 0;

  tile_feedback_drawer_if #(.LW(3), .ROW_W(3), .OFFSET_W(6)) ifa ();
  tile_feedback_drawer_if #(.LW(4), .ROW_W(3), .OFFSET_W(6)) ifb ();

  assign ifa.go     = go & ~sel;
  assign ifa.mode   = mode;
  assign ifa.lane   = 3'(lane);
  assign ifa.row    = row;
  assign ifa.offset = offset;
  assign ifb.go     = go & sel;
  assign ifb.mode   = mode;
  assign ifb.lane   = 4'(lane);
  assign ifb.row    = row;
  assign ifb.offset = offset;

  tile_feedback_drawer dut_a (
    .clock_i (clk),
    .reset_i (rst),
    .bus     (ifa)
  );

  tile_feedback_drawer #(.NUM_LANES(8), .TILE_W(20)) dut_b (
    .clock_i (clk),
    .reset_i (rst),
    .bus     (ifb)
  );

  logic [8:0] ox;
  logic [7:0] oy;
  logic [2:0] ocol;
  logic       oplot, obusy, odone, oerr;
  assign ox    = sel ? ifb.x      : ifa.x;
  assign oy    = sel ? ifb.y      : ifa.y;
  assign ocol  = sel ? ifb.colour : ifa.colour;
  assign oplot = sel ? ifb.plot   : ifa.plot;
  assign obusy = sel ? ifb.busy   : ifa.busy;
  assign odone = sel ? ifb.done   : ifa.done;
  assign oerr  = sel ? ifb.err    : ifa.err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp)
    else begin
      misses++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_x"},      32'(ox),    0);
    chk({tag, "_y"},      32'(oy),    0);
    chk({tag, "_colour"}, 32'(ocol),  0);
    chk({tag, "_plot"},   32'(oplot), 0);
    chk({tag, "_busy"},   32'(obusy), 0);
    chk({tag, "_done"},   32'(odone), 0);
    chk({tag, "_err"},    32'(oerr),  0);
  endtask

  function automatic int tile_w();
    return sel ? 20 : 40;
  endfunction

  function automatic int lanes();
    return sel ? 8 : 4;
  endfunction

  // Called just after an edge while the selected DUT is idle; that cycle
  // is cycle 0 of the request. go_at picks a cycle inside DRAW in which a
  // stray go is raised (0 = none).
  task automatic run_tile(input logic m, input int ln, input int rw, input int off,
                          input int go_at);
    int w, n, ex, ey, ep, plots, vis, top;
    w     = tile_w();
    n     = w * 30;
    plots = 0;
    go = 1'b1; mode = m; lane = ln; row = 3'(rw); offset = 6'(off);
    for (int k = 0; k < n; k++) begin
      step();
      ex = 80 + ln * w + (k % w);
      ey = rw * 30 + off + (k / w);
      ep = (ey < 240) ? 1 : 0;
      chk("draw_busy",   32'(obusy), 1);
      chk("draw_done",   32'(odone), 0);
      chk("draw_plot",   32'(oplot), 32'(ep));
      chk("draw_x",      32'(ox),    32'(ex));
      chk("draw_colour", 32'(ocol),  m ? 32'd4 : 32'd7);
      if (ep == 1) chk("draw_y", 32'(oy), 32'(ey));
      plots += int'(oplot);
      // Scramble inputs; the latched tile must not notice.
      go     = ((k + 1) == go_at);
      mode   = 1'($urandom_range(0, 1));
      lane   = $urandom_range(0, lanes() - 1);
      row    = 3'($urandom_range(0, 7));
      offset = 6'($urandom_range(0, 63));
    end
    step();
    chk("fin_done",   32'(odone), 1);
    chk("fin_busy",   32'(obusy), 1);
    chk("fin_err",    32'(oerr),  0);
    chk("fin_plot",   32'(oplot), 0);
    chk("fin_x",      32'(ox),    0);
    chk("fin_y",      32'(oy),    0);
    chk("fin_colour", 32'(ocol),  0);
    go   = 1'b1;
    lane = 0;
    step();
    chk("post_done", 32'(odone), 0);
    chk("post_busy", 32'(obusy), 0);
    go = 1'b0;
    step();
    chk("post_idle_busy", 32'(obusy), 0);
    chk("post_idle_plot", 32'(oplot), 0);
    top = rw * 30 + off;
    vis = (top >= 240) ? 0 : ((240 - top > 30) ? 30 : 240 - top);
    chk("plot_count", 32'(plots), 32'(vis * w));
  endtask

  task automatic reject(input int ln);
    go = 1'b1; lane = ln; mode = 1'b0;
    step();
    chk("rej_err",  32'(oerr),  1);
    chk("rej_done", 32'(odone), 1);
    chk("rej_busy", 32'(obusy), 1);
    chk("rej_plot", 32'(oplot), 0);
    go = 1'b0;
    step();
    chk("rej_err2",  32'(oerr),  0);
    chk("rej_done2", 32'(odone), 0);
    chk("rej_busy2", 32'(obusy), 0);
    chk("rej_plot2", 32'(oplot), 0);
  endtask

  initial begin
    rst = 1'b1; sel = 1'b0; go = 1'b0; mode = 1'b0; lane = 0; row = '0; offset = '0;
    repeat (3) step();
    chk_quiet("reset_a");
    sel = 1'b1;
    #1;
    chk_quiet("reset_b");
    sel = 1'b0;
    rst = 1'b0;
    step();

    run_tile(1'b0, 2, 6, 0, 500);
    run_tile(1'b1, 0, 7, 20, 0);
    reject(5);
    reject($urandom_range(4, 7));

    for (int t = 0; t < 3; t++)
      run_tile(1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 7),
               $urandom_range(0, 63), $urandom_range(0, 1199));

    go = 1'b1; mode = 1'b0; lane = 1; row = 3'd2; offset = 6'd5;
    for (int k = 1; k < 300; k++) begin
      step();
      go = 1'b0;
    end
    step();
    rst = 1'b1;
    go  = 1'b1;
    step();
    chk_quiet("mid_reset");
    rst = 1'b0;
    go  = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("after_reset_done", 32'(odone), 0);
      chk("after_reset_busy", 32'(obusy), 0);
    end
    run_tile(1'b1, 3, 1, 9, 0);

    sel = 1'b1;
    step();
    run_tile(1'b0, 7, 0, 0, 0);
    run_tile(1'($urandom_range(0, 1)), $urandom_range(0, 7), $urandom_range(0, 7),
             $urandom_range(0, 63), 0);
    reject($urandom_range(8, 15));

    $display("== %0d vectors applied, %0d miscompares ==", vecs, misses);
    $finish;
  end

endmodule
